// File: rtl/ncl_pkg.sv
// Shared definitions for NCL-to-clock boundary blocks: rail width, sink FSM
// states and the 1-of-4 token decoder.
package ncl_pkg;

  localparam int RAILS = 4;

  typedef enum logic [1:0] {
    REQ_DATA,
    REQ_NULL,
    HOLD
  } sink_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] value;
    logic       illegal;
  } token_t;

  // All-low rails are NULL (neither valid nor illegal); more than one rail high is illegal.
  function automatic token_t onehot4_decode(input logic [RAILS-1:0] rails);
    token_t t;
    t = '0;
    case (rails)
      4'b0000: ;
      4'b0001: begin t.valid = 1'b1; t.value = 2'd0; end
      4'b0010: begin t.valid = 1'b1; t.value = 2'd1; end
      4'b0100: begin t.valid = 1'b1; t.value = 2'd2; end
      4'b1000: begin t.valid = 1'b1; t.value = 2'd3; end
      default: t.illegal = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ncl4_sync_sink_if.sv
// Bundle of the NCL rail handshake and the clocked valid/ready token stream.
// master = the sink itself, slave = the surrounding pipeline and consumer.
interface ncl4_sync_sink_if #(
  parameter int CNT_W = 16
);

  logic [ncl_pkg::RAILS-1:0] rail_in;
  logic                      comp_out;
  logic [1:0]                out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CNT_W-1:0]          token_count;
  logic                      err_illegal;

  modport master (
    input  rail_in,
    input  out_ready,
    output comp_out,
    output out_data,
    output out_valid,
    output token_count,
    output err_illegal
  );

  modport slave (
    output rail_in,
    output out_ready,
    input  comp_out,
    input  out_data,
    input  out_valid,
    input  token_count,
    input  err_illegal
  );

endinterface

// File: rtl/ncl_sync_fifo.sv
// Small synchronous FIFO with a registered head: an entry becomes visible on
// the edge after it is written, never in the same cycle.
module ncl_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CW-1:0]    remain;
  logic             pop;
  logic             do_push;

  assign pop     = out_valid & out_ready;
  assign do_push = push & (count != CW'(DEPTH));
  assign rd_next = rd_ptr + PTR_W'(pop);
  // Entries already stored before this edge, minus the one leaving; this
  // deliberately excludes a same-cycle push so the head never falls through.
  assign remain  = count - CW'(pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      count     <= count + CW'(do_push) - CW'(pop);
      out_valid <= (remain != '0);
      if (remain != '0) out_data <= mem[rd_next];
    end
  end

endmodule

// File: rtl/ncl4_sync_sink.sv
// Clocked tail consumer for a 1-of-4 NCL pipeline: synchronizes the rails,
// acknowledges each DATA/NULL wavefront and queues decoded tokens.
module ncl4_sync_sink
  import ncl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              init_n,
  ncl4_sync_sink_if.master  bus
);

  localparam int FCW = $clog2(DEPTH + 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [RAILS-1:0] sync_q [SYNC_STAGES];
  token_t           tok;
  sink_state_t      state;
  sink_state_t      state_d;
  logic             push;
  logic             err_set;
  logic             err_q;
  logic [CNT_W-1:0] tok_cnt;
  logic [FCW-1:0]   fifo_count;
  logic             full;

  // Reset asserts asynchronously but releases only after two clock edges.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rail_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign tok  = onehot4_decode(sync_q[SYNC_STAGES-1]);
  assign full = (fifo_count == FCW'(DEPTH));

  always_comb begin
    state_d = state;
    push    = 1'b0;
    err_set = tok.illegal;
    case (state)
      REQ_DATA: begin
        if (tok.valid) begin
          push    = 1'b1;
          state_d = REQ_NULL;
        end
      end
      REQ_NULL: begin
        if (!tok.valid && !tok.illegal) state_d = full ? HOLD : REQ_DATA;
      end
      HOLD: begin
        // Upstream must stay NULL while we withhold the DATA request.
        if (tok.valid)                      err_set = 1'b1;
        else if (!tok.illegal && !full)     state_d = REQ_DATA;
      end
      default: state_d = REQ_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REQ_DATA;
      err_q   <= 1'b0;
      tok_cnt <= '0;
    end else begin
      state <= state_d;
      if (err_set) err_q   <= 1'b1;
      if (push)    tok_cnt <= tok_cnt + CNT_W'(1);
    end
  end

  assign bus.comp_out    = (state != REQ_DATA);
  assign bus.token_count = tok_cnt;
  assign bus.err_illegal = err_q;

  ncl_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (tok.value),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ncl4_sync_sink.sv
// Directed bench for ncl4_sync_sink (DEPTH=4, SYNC_STAGES=2, CNT_W=3 so the
// token counter wrap is reachable with a handful of tokens).
module tb_ncl4_sync_sink;

  logic clk;
  logic init_n;
  int   vectors;
  int   miscompares;
  logic [2:0] exp_tc;
  logic [1:0] popped[$];

  ncl4_sync_sink_if #(.CNT_W(3)) bus ();

  ncl4_sync_sink #(
    .DEPTH       (4),
    .SYNC_STAGES (2),
    .CNT_W       (3)
  ) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every head the consumer takes; inputs only change just after posedge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) popped.push_back(bus.out_data);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_comp(input logic exp, input string name);
    int i;
    i = 0;
    while (bus.comp_out !== exp && i < 40) begin
      step(1);
      i++;
    end
    vectors++;
    if (bus.comp_out !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: comp_out=%b, expected %b within 40 edges", name, bus.comp_out, exp);
    end
  endtask

  task automatic send_token(input logic [1:0] v);
    wait_comp(1'b0, "req_data");
    bus.rail_in = 4'b0001 << v;
    wait_comp(1'b1, "ack_data");
    exp_tc = exp_tc + 3'd1;
    bus.rail_in = 4'b0000;
  endtask

  task automatic release_reset();
    step(2);
    init_n = 1'b1;
    step(4);
    exp_tc = 3'd0;
  endtask

  task automatic test_reset();
    init_n = 1'b1;
    bus.rail_in = 4'b0000;
    bus.out_ready = 1'b0;
    #2 init_n = 1'b0;
    #1;
    vectors += 5;
    if (bus.comp_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_comp: got %b want 0", bus.comp_out); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", bus.out_valid); end
    if (bus.out_data !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_data: got %0d want 0", bus.out_data); end
    if (bus.token_count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", bus.token_count); end
    if (bus.err_illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", bus.err_illegal); end
    release_reset();
  endtask

  task automatic test_single_token();
    int k;
    bus.out_ready = 1'b1;
    bus.rail_in = 4'b0100;
    k = 0;
    while (bus.comp_out !== 1'b1 && k < 10) begin step(1); k++; end
    exp_tc = exp_tc + 3'd1;
    vectors += 2;
    if (k !== 3) begin miscompares++; $display("[TB] FAIL data_latency: got %0d edges want 3", k); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL no_fallthrough: out_valid=%b want 0", bus.out_valid); end
    step(1);
    vectors += 3;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid: got %b want 1", bus.out_valid); end
    if (bus.out_data !== 2'd2) begin miscompares++; $display("[TB] FAIL single_data: got %0d want 2", bus.out_data); end
    if (bus.token_count !== exp_tc) begin miscompares++; $display("[TB] FAIL single_count: got %0d want %0d", bus.token_count, exp_tc); end
    step(1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pulse: out_valid=%b want 0", bus.out_valid); end
    bus.rail_in = 4'b0000;
    k = 0;
    while (bus.comp_out !== 1'b0 && k < 10) begin step(1); k++; end
    vectors++;
    if (k !== 3) begin miscompares++; $display("[TB] FAIL null_latency: got %0d edges want 3", k); end
  endtask

  task automatic test_stream();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3};
    bus.out_ready = 1'b1;
    popped.delete();
    for (int i = 0; i < 4; i++) send_token(exp_seq[i]);
    wait_comp(1'b0, "stream_end");
    step(4);
    vectors++;
    if (popped.size() !== 4) begin miscompares++; $display("[TB] FAIL stream_len: got %0d want 4", popped.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= popped.size() || popped[i] !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL stream_data[%0d]: got %0d want %0d", i, (i < popped.size()) ? popped[i] : 2'bxx, exp_seq[i]);
      end
    end
    vectors += 2;
    if (bus.token_count !== exp_tc) begin miscompares++; $display("[TB] FAIL stream_count: got %0d want %0d", bus.token_count, exp_tc); end
    if (bus.err_illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_err: got %b want 0", bus.err_illegal); end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    bus.out_ready = 1'b0;
    popped.delete();
    for (int i = 0; i < 4; i++) send_token(exp_seq[i]);
    step(6);
    vectors += 3;
    if (bus.comp_out !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_comp: got %b want 1", bus.comp_out); end
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_valid: got %b want 1", bus.out_valid); end
    if (bus.out_data !== 2'd1) begin miscompares++; $display("[TB] FAIL hold_head: got %0d want 1", bus.out_data); end
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.comp_out !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_exit_early: comp_out=%b want 1", bus.comp_out); end
    step(1);
    vectors++;
    if (bus.comp_out !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_exit: comp_out=%b want 0", bus.comp_out); end
    send_token(exp_seq[4]);
    bus.out_ready = 1'b1;
    step(10);
    wait_comp(1'b0, "bp_drain");
    vectors++;
    if (popped.size() !== 5) begin miscompares++; $display("[TB] FAIL bp_len: got %0d want 5", popped.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= popped.size() || popped[i] !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL bp_data[%0d]: got %0d want %0d", i, (i < popped.size()) ? popped[i] : 2'bxx, exp_seq[i]);
      end
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b0;
    popped.delete();
    bus.rail_in = 4'b0011;
    step(5);
    vectors += 4;
    if (bus.err_illegal !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_err: got %b want 1", bus.err_illegal); end
    if (bus.comp_out !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_comp: got %b want 0", bus.comp_out); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_push: out_valid=%b want 0", bus.out_valid); end
    if (bus.token_count !== exp_tc) begin miscompares++; $display("[TB] FAIL illegal_count: got %0d want %0d", bus.token_count, exp_tc); end
    bus.rail_in = 4'b0000;
    step(3);
    send_token(2'd3);
    step(2);
    vectors += 3;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL legal_valid: got %b want 1", bus.out_valid); end
    if (bus.out_data !== 2'd3) begin miscompares++; $display("[TB] FAIL legal_data: got %0d want 3", bus.out_data); end
    if (bus.err_illegal !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky: got %b want 1", bus.err_illegal); end
    bus.out_ready = 1'b1;
    step(3);
    wait_comp(1'b0, "illegal_done");
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send_token(2'd2);
    wait_comp(1'b0, "mid_req_data");
    bus.rail_in = 4'b0010;
    wait_comp(1'b1, "mid_req_null");
    step(1);
    vectors++;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_valid: got %b want 1", bus.out_valid); end
    init_n = 1'b0;
    #1;
    vectors += 4;
    if (bus.comp_out !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_comp: got %b want 0", bus.comp_out); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid: got %b want 0", bus.out_valid); end
    if (bus.token_count !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_count: got %0d want 0", bus.token_count); end
    if (bus.err_illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_err: got %b want 0", bus.err_illegal); end
    bus.rail_in = 4'b0000;
    release_reset();
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    popped.delete();
    for (int i = 0; i < 9; i++) send_token(2'(i));
    wait_comp(1'b0, "wrap_end");
    step(4);
    vectors += 2;
    if (bus.token_count !== exp_tc) begin miscompares++; $display("[TB] FAIL wrap_count: got %0d want %0d", bus.token_count, exp_tc); end
    if (popped.size() !== 9) begin miscompares++; $display("[TB] FAIL wrap_len: got %0d want 9", popped.size()); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_tc = 3'd0;
    test_reset();
    test_single_token();
    test_stream();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
